// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

    typedef enum logic {
        ALU_PRI,
        LD_PRI
    } wb_state_t;

    localparam int unsigned WB_WORD_WIDTH    = 32;
    localparam int unsigned WB_ADDRESS_WIDTH = 5;

    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] rd;
        logic [WB_WORD_WIDTH-1:0]    data;
    } wb_req_t;

    localparam logic [WB_ADDRESS_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO used as the load-result queue.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued load returns into one
// registered register-file write per cycle. Optional counters: WB_PERF_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int LQ_DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
    input  logic [WORD_WIDTH-1:0]       alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [ADDRESS_WIDTH-1:0]    ld_rd,
    input  logic [WORD_WIDTH-1:0]       ld_data,
    output logic                        WEN,
    output logic [ADDRESS_WIDTH-1:0]    WA3,
    output logic [WORD_WIDTH-1:0]       WD3,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
`ifdef WB_PERF_EN
    ,
    output logic [31:0]                 wb_writes,
    output logic [31:0]                 alu_stalls
`endif
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam int EW = ADDRESS_WIDTH + WORD_WIDTH;

    wb_state_t state, next_state;

    logic                     lq_full;
    logic                     lq_empty;
    logic                     lq_push;
    logic                     lq_pop;
    logic [EW-1:0]            lq_head;
    logic                     use_alu;
    logic                     sel_valid;
    logic [ADDRESS_WIDTH-1:0] sel_rd;
    logic [WORD_WIDTH-1:0]    sel_data;
    logic [CW-1:0]            next_count;

    assign ld_ready = !lq_full;
    assign lq_push  = ld_valid && !lq_full;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lq_push),
        .push_data ({ld_rd, ld_data}),
        .pop       (lq_pop),
        .pop_data  (lq_head),
        .full      (lq_full),
        .empty     (lq_empty),
        .count     (lq_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ALU_PRI;
        else        state <= next_state;
    end

    // Transitions look at the post-edge occupancy so the switch takes
    // effect in the cycle right after the queue fills or empties.
    always_comb begin
        next_state = state;
        alu_ready  = 1'b0;
        use_alu    = 1'b0;
        lq_pop     = 1'b0;
        next_count = lq_count;
        case (state)
            ALU_PRI: begin
                alu_ready = 1'b1;
                if (alu_valid)      use_alu = 1'b1;
                else if (!lq_empty) lq_pop  = 1'b1;
            end
            LD_PRI: begin
                lq_pop = !lq_empty;
            end
            default: ;
        endcase
        next_count = lq_count + CW'(lq_push) - CW'(lq_pop);
        if (state == ALU_PRI && next_count == CW'(LQ_DEPTH)) next_state = LD_PRI;
        if (state == LD_PRI && next_count == '0)             next_state = ALU_PRI;
    end

    assign sel_valid = use_alu || lq_pop;
    assign sel_rd    = use_alu ? alu_rd   : lq_head[EW-1:WORD_WIDTH];
    assign sel_data  = use_alu ? alu_data : lq_head[WORD_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WEN <= 1'b0;
            WA3 <= '0;
            WD3 <= '0;
        end else begin
            WEN <= sel_valid && (sel_rd != ADDRESS_WIDTH'(REG_ZERO));
            if (sel_valid) begin
                WA3 <= sel_rd;
                WD3 <= sel_data;
            end
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_writes  <= '0;
            alu_stalls <= '0;
        end else begin
            if (WEN)                     wb_writes  <= wb_writes + 32'd1;
            if (alu_valid && !alu_ready) alu_stalls <= alu_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (counters checked when WB_PERF_EN).
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        WEN;
    logic [4:0]  WA3;
    logic [31:0] WD3;
    logic [1:0]  lq_count;
`ifdef WB_PERF_EN
    logic [31:0] wb_writes;
    logic [31:0] alu_stalls;
`endif

    int vectors    = 0;
    int miscompares = 0;

    wb_arbiter #(
        .WORD_WIDTH    (32),
        .ADDRESS_WIDTH (5),
        .LQ_DEPTH      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .WEN       (WEN),
        .WA3       (WA3),
        .WD3       (WD3),
        .lq_count  (lq_count)
`ifdef WB_PERF_EN
        ,
        .wb_writes  (wb_writes),
        .alu_stalls (alu_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow immediately.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        #12;
        chk("rst_wen", WEN, 0);
        chk("rst_wa3", WA3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_cnt", lq_count, 0);
        chk("rst_ldrdy", ld_ready, 1);
        chk("rst_alurdy", alu_ready, 1);
        rst_n = 1'b1;
        tick();

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        chk("alu_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("alu_wen", WEN, 1);
        chk("alu_wa3", WA3, 5);
        chk("alu_wd3", WD3, 32'hDEADBEEF);
        tick();
        chk("idle_wen", WEN, 0);
        chk("idle_wa3_hold", WA3, 5);
        chk("idle_wd3_hold", WD3, 32'hDEADBEEF);

        // x0 filter on both paths
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        chk("x0_alu_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("x0_alu_wen", WEN, 0);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        chk("x0_ld_rdy", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        chk("x0_ld_cnt1", lq_count, 1);
        chk("x0_ld_wen_a", WEN, 0);
        tick();
        chk("x0_ld_cnt0", lq_count, 0);
        chk("x0_ld_wen_b", WEN, 0);

        // priority and drain: r4, r4, r3
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hB;
        tick();
        ld_valid = 1'b0;
        chk("pri1_wen", WEN, 1);
        chk("pri1_wa3", WA3, 4);
        chk("pri1_wd3", WD3, 32'hB);
        chk("pri1_cnt", lq_count, 1);
        tick();
        alu_valid = 1'b0;
        chk("pri2_wa3", WA3, 4);
        chk("pri2_cnt", lq_count, 1);
        tick();
        chk("pri3_wen", WEN, 1);
        chk("pri3_wa3", WA3, 3);
        chk("pri3_wd3", WD3, 32'hA);
        chk("pri3_cnt", lq_count, 0);
        tick();
        chk("pri4_wen", WEN, 0);

        // queue full: ALU throttled, r1 then r2 drain back to back
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h11;
        tick();
        ld_rd = 5'd2; ld_data = 32'h22;
        chk("full1_cnt", lq_count, 1);
        chk("full1_ldrdy", ld_ready, 1);
        chk("full1_wa3", WA3, 7);
        tick();
        ld_valid = 1'b0;
        chk("full2_cnt", lq_count, 2);
        chk("full2_ldrdy", ld_ready, 0);
        chk("full2_alurdy", alu_ready, 0);
        tick();
        chk("full3_wen", WEN, 1);
        chk("full3_wa3", WA3, 1);
        chk("full3_wd3", WD3, 32'h11);
        chk("full3_alurdy", alu_ready, 0);
        chk("full3_cnt", lq_count, 1);
        tick();
        chk("full4_wen", WEN, 1);
        chk("full4_wa3", WA3, 2);
        chk("full4_wd3", WD3, 32'h22);
        chk("full4_alurdy", alu_ready, 1);
        chk("full4_cnt", lq_count, 0);
        tick();
        alu_valid = 1'b0;
        chk("full5_wa3", WA3, 7);
        chk("full5_wd3", WD3, 32'h70);

        // reset mid-drain with a full queue
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h11;
        tick();
        ld_rd = 5'd2; ld_data = 32'h22;
        tick();
        chk("rmd_cnt_pre", lq_count, 2);
        rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("rmd_wen", WEN, 0);
        chk("rmd_cnt", lq_count, 0);
        chk("rmd_alurdy", alu_ready, 1);
        chk("rmd_ldrdy", ld_ready, 1);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_wen", WEN, 0);
            chk("post_rst_cnt", lq_count, 0);
        end

`ifdef WB_PERF_EN
        // 3 real writes (r9 x3) and 2 stall cycles; x0 loads are silent
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0;
        tick();
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        tick();
        alu_valid = 1'b0;
        tick();
        chk("perf_writes", wb_writes, 3);
        chk("perf_stalls", alu_stalls, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
